// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle controller and its datapath.
// Holds the FSM state codes, the decoded opcodes, the mux/ALU select
// encodings and the error codes so both sides agree on one set of values.
package multi_cycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IF   = 4'd0,
        S_ID   = 4'd1,
        S_MA   = 4'd2,
        S_MRD  = 4'd3,
        S_MWB  = 4'd4,
        S_MWR  = 4'd5,
        S_EXR  = 4'd6,
        S_WBR  = 4'd7,
        S_BR   = 4'd8,
        S_JMP  = 4'd9,
        S_EXI  = 4'd10,
        S_WBI  = 4'd11,
        S_HALT = 4'd15
    } state_t;

    // IR[31:26] values understood by the decoder
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // PC source mux
    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    // ALU B operand mux
    localparam logic [1:0] ALUB_RT     = 2'b00;
    localparam logic [1:0] ALUB_FOUR   = 2'b01;
    localparam logic [1:0] ALUB_IMM    = 2'b10;
    localparam logic [1:0] ALUB_IMM_S2 = 2'b11;

    // ALU operation
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // Error codes reported in HALT
    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // States that wait on mem_ready and are guarded by the wait counter
    function automatic logic is_wait_state(input state_t s);
        return (s == S_IF) || (s == S_MRD) || (s == S_MWR);
    endfunction

endpackage

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle processor control FSM.
// Sequences fetch, decode, memory, execute, write-back, branch and jump
// states and drives the datapath enables and mux selects from the state.
// Ports:
//   clk, rst (async, active-low)
//   opcode[5:0], zero, mem_ready            : inputs from IR, ALU and memory
//   mem_req, mem_we, iord                   : memory request / write / address select
//   ir_we, pc_we, reg_we                    : register write enables
//   pc_src[1:0], reg_dst, mem_to_reg,
//   alu_src_a, alu_src_b[1:0], alu_op[1:0]  : datapath selects
//   state[3:0]                              : current state code (debug)
//   retire                                  : pulse when an instruction completes
//   halt, err_code[1:0]                     : halted flag and reason
module multi_cycle_ctrl
    import multi_cycle_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_we,
    output logic       pc_we,
    output logic       reg_we,
    output logic [1:0] pc_src,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [3:0] state,
    output logic       retire,
    output logic       halt,
    output logic [1:0] err_code
);

    // Memory handshake: a request is held (mem_req=1) in IF/MRD/MWR until
    // the memory answers with mem_ready=1 in the same cycle; that cycle
    // completes the transfer and the FSM moves on at the next edge.

    localparam int CW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

    state_t        state_q, state_next;
    logic [1:0]    err_q, err_next;
    logic [CW-1:0] wait_cnt;
    logic          timeout;

    assign timeout  = (wait_cnt == CW'(WAIT_MAX)) && !mem_ready;
    assign state    = state_q;
    assign err_code = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IF;
            err_q    <= ERR_NONE;
            wait_cnt <= '0;
        end else begin
            state_q <= state_next;
            err_q   <= err_next;
            // Counting only while a wait state holds; any entry clears it.
            if (is_wait_state(state_q) && (state_next == state_q))
                wait_cnt <= wait_cnt + CW'(1);
            else
                wait_cnt <= '0;
        end
    end

    always_comb begin
        state_next = state_q;
        err_next   = err_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        reg_we     = 1'b0;
        pc_src     = PC_SRC_ALU;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = ALUB_RT;
        alu_op     = ALU_ADD;
        retire     = 1'b0;
        halt       = 1'b0;

        unique case (state_q)
            S_IF: begin
                mem_req   = 1'b1;
                alu_src_b = ALUB_FOUR;
                // mem_ready beats a coincident timeout
                if (mem_ready) begin
                    ir_we      = 1'b1;
                    pc_we      = 1'b1;
                    state_next = S_ID;
                end else if (timeout) begin
                    state_next = S_HALT;
                    err_next   = ERR_TIMEOUT;
                end
            end
            S_ID: begin
                alu_src_b = ALUB_IMM_S2;
                case (opcode)
                    OP_RTYPE:     state_next = S_EXR;
                    OP_LW, OP_SW: state_next = S_MA;
                    OP_BEQ:       state_next = S_BR;
                    OP_J:         state_next = S_JMP;
                    OP_ADDI:      state_next = S_EXI;
                    default: begin
                        state_next = S_HALT;
                        err_next   = ERR_ILLEGAL;
                    end
                endcase
            end
            S_MA: begin
                alu_src_a  = 1'b1;
                alu_src_b  = ALUB_IMM;
                state_next = (opcode == OP_LW) ? S_MRD : S_MWR;
            end
            S_MRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    state_next = S_MWB;
                end else if (timeout) begin
                    state_next = S_HALT;
                    err_next   = ERR_TIMEOUT;
                end
            end
            S_MWR: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = 1'b1;
                if (mem_ready) begin
                    retire     = 1'b1;
                    state_next = S_IF;
                end else if (timeout) begin
                    state_next = S_HALT;
                    err_next   = ERR_TIMEOUT;
                end
            end
            S_MWB: begin
                reg_we     = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_next = S_IF;
            end
            S_EXR: begin
                alu_src_a  = 1'b1;
                alu_op     = ALU_FUNCT;
                state_next = S_WBR;
            end
            S_WBR: begin
                reg_we     = 1'b1;
                reg_dst    = 1'b1;
                retire     = 1'b1;
                state_next = S_IF;
            end
            S_EXI: begin
                alu_src_a  = 1'b1;
                alu_src_b  = ALUB_IMM;
                state_next = S_WBI;
            end
            S_WBI: begin
                reg_we     = 1'b1;
                retire     = 1'b1;
                state_next = S_IF;
            end
            S_BR: begin
                alu_src_a  = 1'b1;
                alu_op     = ALU_SUB;
                pc_src     = PC_SRC_ALUOUT;
                pc_we      = zero;
                retire     = 1'b1;
                state_next = S_IF;
            end
            S_JMP: begin
                pc_src     = PC_SRC_JUMP;
                pc_we      = 1'b1;
                retire     = 1'b1;
                state_next = S_IF;
            end
            S_HALT: begin
                halt = 1'b1;
            end
            default: begin
                state_next = S_HALT;
            end
        endcase

        // While reset is low nothing may leave the controller, even though
        // the state register already reads IF.
        if (!rst) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            iord       = 1'b0;
            ir_we      = 1'b0;
            pc_we      = 1'b0;
            reg_we     = 1'b0;
            pc_src     = 2'b00;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            alu_op     = 2'b00;
            retire     = 1'b0;
            halt       = 1'b0;
        end
    end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Testbench for multi_cycle_ctrl: per-cycle stimulus and expected states are
// queued together, then replayed while observed state, controls and error
// code are compared against a table of the documented per-state outputs.
module tb_multi_cycle_ctrl;
    import multi_cycle_ctrl_pkg::*;

    logic       clk, rst, zero, mem_ready;
    logic [5:0] opcode;
    logic       mem_req, mem_we, iord, ir_we, pc_we, reg_we;
    logic [1:0] pc_src, alu_src_b, alu_op, err_code;
    logic       reg_dst, mem_to_reg, alu_src_a, retire, halt;
    logic [3:0] state;
    logic [16:0] ctl;

    multi_cycle_ctrl #(.WAIT_MAX(15)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_we(ir_we),
        .pc_we(pc_we), .reg_we(reg_we), .pc_src(pc_src), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .state(state), .retire(retire), .halt(halt),
        .err_code(err_code)
    );

    assign ctl = {mem_req, mem_we, iord, ir_we, pc_we, reg_we, pc_src, reg_dst,
                  mem_to_reg, alu_src_a, alu_src_b, alu_op, retire, halt};

    int checks = 0;
    int errors = 0;
    int n_ret, n_mrd, n_busy;
    logic [1:0]  task_err;
    logic [3:0]  exp_s;
    logic [33:0] exp_m;

    // Scoreboard: expected state plus the stimulus to drive in that cycle
    logic [3:0] exp_q[$];
    logic       rdy_q[$];
    logic       zero_q[$];
    logic [5:0] op_q[$];

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    // Expected {value, care-mask} of ctl for a state, from the output table.
    function automatic logic [33:0] model(input logic [3:0] st, input logic rdy, input logic z);
        logic [16:0] v, m;
        v = '0;
        m = 17'b1_1011_1000_0000_0011; // enables always checked
        case (st)
            S_IF:   begin v[16] = 1'b1; m[14] = 1'b1; m[6] = 1'b1; v[5:4] = 2'b01; m[5:4] = 2'b11;
                          m[3:2] = 2'b11; m[10:9] = 2'b11; v[13] = rdy; v[12] = rdy; end
            S_ID:   begin m[6] = 1'b1; v[5:4] = 2'b11; m[5:4] = 2'b11; m[3:2] = 2'b11; end
            S_MA:   begin v[6] = 1'b1; m[6] = 1'b1; v[5:4] = 2'b10; m[5:4] = 2'b11; m[3:2] = 2'b11; end
            S_MRD:  begin v[16] = 1'b1; v[14] = 1'b1; m[14] = 1'b1; end
            S_MWR:  begin v[16] = 1'b1; v[15] = 1'b1; v[14] = 1'b1; m[14] = 1'b1; v[1] = rdy; end
            S_MWB:  begin v[11] = 1'b1; m[8] = 1'b1; v[7] = 1'b1; m[7] = 1'b1; v[1] = 1'b1; end
            S_EXR:  begin v[6] = 1'b1; m[6] = 1'b1; m[5:4] = 2'b11; v[3:2] = 2'b10; m[3:2] = 2'b11; end
            S_WBR:  begin v[11] = 1'b1; v[8] = 1'b1; m[8] = 1'b1; m[7] = 1'b1; v[1] = 1'b1; end
            S_EXI:  begin v[6] = 1'b1; m[6] = 1'b1; v[5:4] = 2'b10; m[5:4] = 2'b11; m[3:2] = 2'b11; end
            S_WBI:  begin v[11] = 1'b1; m[8] = 1'b1; m[7] = 1'b1; v[1] = 1'b1; end
            S_BR:   begin v[6] = 1'b1; m[6] = 1'b1; m[5:4] = 2'b11; v[3:2] = 2'b01; m[3:2] = 2'b11;
                          v[10:9] = 2'b01; m[10:9] = 2'b11; v[12] = z; v[1] = 1'b1; end
            S_JMP:  begin v[10:9] = 2'b10; m[10:9] = 2'b11; v[12] = 1'b1; v[1] = 1'b1; end
            S_HALT: begin v[0] = 1'b1; end
            default: m = '1;
        endcase
        return {v, m};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic push(input logic [3:0] st, input logic rdy, input logic z, input logic [5:0] op);
        exp_q.push_back(st);
        rdy_q.push_back(rdy);
        zero_q.push_back(z);
        op_q.push_back(op);
    endtask

    // Queue one instruction: w_if idle fetch cycles, w_mem idle memory cycles.
    task automatic push_instr(input logic [5:0] op, input logic z, input int w_if, input int w_mem);
        for (int i = 0; i < w_if; i++) push(S_IF, 1'b0, z, op);
        push(S_IF, 1'b1, z, op);
        push(S_ID, 1'($urandom_range(0, 1)), z, op);
        case (op)
            OP_RTYPE: begin push(S_EXR, 1'($urandom_range(0, 1)), z, op); push(S_WBR, 1'($urandom_range(0, 1)), z, op); end
            OP_LW: begin
                push(S_MA, 1'($urandom_range(0, 1)), z, op);
                for (int i = 0; i < w_mem; i++) push(S_MRD, 1'b0, z, op);
                push(S_MRD, 1'b1, z, op);
                push(S_MWB, 1'($urandom_range(0, 1)), z, op);
            end
            OP_SW: begin
                push(S_MA, 1'($urandom_range(0, 1)), z, op);
                for (int i = 0; i < w_mem; i++) push(S_MWR, 1'b0, z, op);
                push(S_MWR, 1'b1, z, op);
            end
            OP_BEQ:  push(S_BR, 1'($urandom_range(0, 1)), z, op);
            OP_J:    push(S_JMP, 1'($urandom_range(0, 1)), z, op);
            OP_ADDI: begin push(S_EXI, 1'($urandom_range(0, 1)), z, op); push(S_WBI, 1'($urandom_range(0, 1)), z, op); end
            default: push(S_HALT, 1'($urandom_range(0, 1)), z, op);
        endcase
    endtask

    task automatic clear_counts(input logic [1:0] e);
        n_ret = 0; n_mrd = 0; n_busy = 0; task_err = e;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0; mem_ready = 1'b1; zero = 1'b0; opcode = OP_RTYPE;
        #3;
        checks++;
        if (state !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
        tick(); tick();
        checks++;
        if (ctl !== 17'd0) begin errors++; $display("FAIL reset_outputs: got %b want all zero", ctl); end
        checks++;
        if (err_code !== 2'b00) begin errors++; $display("FAIL reset_err: got %b want 00", err_code); end
        rst = 1'b1;
        mem_ready = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b1 || state !== 4'd0) begin errors++; $display("FAIL reset_release: mem_req=%b state=%0d want 1/0", mem_req, state); end
    endtask

    task automatic test_rtype();
        clear_counts(2'b00);
        push_instr(OP_RTYPE, 1'b0, 0, 0);
        while (exp_q.size() != 0) begin
            mem_ready = rdy_q.pop_front(); zero = zero_q.pop_front(); opcode = op_q.pop_front(); #1;
            exp_s = exp_q.pop_front(); exp_m = model(exp_s, mem_ready, zero);
            checks++; if (state !== exp_s) begin errors++; $display("FAIL rtype_state: got %0d want %0d", state, exp_s); end
            checks++; if (((ctl ^ exp_m[33:17]) & exp_m[16:0]) !== 17'd0) begin errors++; $display("FAIL rtype_ctl: got %b want %b mask %b", ctl, exp_m[33:17], exp_m[16:0]); end
            if (retire === 1'b1) n_ret++;
            tick();
        end
        checks++;
        if (state !== 4'(S_IF) || n_ret != 1) begin errors++; $display("FAIL rtype_end: state=%0d retires=%0d want 0/1", state, n_ret); end
    endtask

    task automatic test_lw();
        clear_counts(2'b00);
        push_instr(OP_LW, 1'b0, 0, 3);
        while (exp_q.size() != 0) begin
            mem_ready = rdy_q.pop_front(); zero = zero_q.pop_front(); opcode = op_q.pop_front(); #1;
            exp_s = exp_q.pop_front(); exp_m = model(exp_s, mem_ready, zero);
            checks++; if (state !== exp_s) begin errors++; $display("FAIL lw_state: got %0d want %0d", state, exp_s); end
            checks++; if (((ctl ^ exp_m[33:17]) & exp_m[16:0]) !== 17'd0) begin errors++; $display("FAIL lw_ctl: got %b want %b mask %b", ctl, exp_m[33:17], exp_m[16:0]); end
            if (state == 4'(S_MRD)) n_mrd++;
            if (state != 4'(S_IF)) n_busy++;
            tick();
        end
        checks++;
        if (n_mrd != 4) begin errors++; $display("FAIL lw_mrd_cycles: got %0d want 4", n_mrd); end
        checks++;
        if (n_busy != 7) begin errors++; $display("FAIL lw_cycles_after_fetch: got %0d want 7", n_busy); end
        // ready arriving exactly when the counter reaches WAIT_MAX is accepted
        push_instr(OP_LW, 1'b1, 0, 15);
        while (exp_q.size() != 0) begin
            mem_ready = rdy_q.pop_front(); zero = zero_q.pop_front(); opcode = op_q.pop_front(); #1;
            exp_s = exp_q.pop_front(); exp_m = model(exp_s, mem_ready, zero);
            checks++; if (state !== exp_s) begin errors++; $display("FAIL lw_edge_state: got %0d want %0d", state, exp_s); end
            checks++; if (((ctl ^ exp_m[33:17]) & exp_m[16:0]) !== 17'd0) begin errors++; $display("FAIL lw_edge_ctl: got %b want %b mask %b", ctl, exp_m[33:17], exp_m[16:0]); end
            tick();
        end
    endtask

    task automatic test_beq();
        clear_counts(2'b00);
        push_instr(OP_BEQ, 1'b0, 1, 0);
        push_instr(OP_BEQ, 1'b1, 0, 0);
        while (exp_q.size() != 0) begin
            mem_ready = rdy_q.pop_front(); zero = zero_q.pop_front(); opcode = op_q.pop_front(); #1;
            exp_s = exp_q.pop_front(); exp_m = model(exp_s, mem_ready, zero);
            checks++; if (state !== exp_s) begin errors++; $display("FAIL beq_state: got %0d want %0d", state, exp_s); end
            checks++; if (((ctl ^ exp_m[33:17]) & exp_m[16:0]) !== 17'd0) begin errors++; $display("FAIL beq_ctl: got %b want %b mask %b", ctl, exp_m[33:17], exp_m[16:0]); end
            if (retire === 1'b1) n_ret++;
            tick();
        end
        checks++;
        if (n_ret != 2) begin errors++; $display("FAIL beq_retire: got %0d want 2", n_ret); end
    endtask

    task automatic test_illegal();
        clear_counts(ERR_ILLEGAL);
        push_instr(6'b111111, 1'b0, 0, 0);
        for (int i = 0; i < 99; i++) push(S_HALT, 1'($urandom_range(0, 1)), 1'b0, 6'b111111);
        while (exp_q.size() != 0) begin
            mem_ready = rdy_q.pop_front(); zero = zero_q.pop_front(); opcode = op_q.pop_front(); #1;
            exp_s = exp_q.pop_front(); exp_m = model(exp_s, mem_ready, zero);
            checks++; if (state !== exp_s) begin errors++; $display("FAIL illegal_state: got %0d want %0d", state, exp_s); end
            checks++; if (((ctl ^ exp_m[33:17]) & exp_m[16:0]) !== 17'd0) begin errors++; $display("FAIL illegal_ctl: got %b want %b mask %b", ctl, exp_m[33:17], exp_m[16:0]); end
            checks++; if (err_code !== ((exp_s == 4'(S_HALT)) ? task_err : 2'b00)) begin errors++; $display("FAIL illegal_err: got %b in state %0d", err_code, exp_s); end
            tick();
        end
        do_reset();
        #1;
        checks++;
        if (err_code !== 2'b00 || state !== 4'(S_IF) || halt !== 1'b0) begin errors++; $display("FAIL illegal_recover: err=%b state=%0d halt=%b want 00/0/0", err_code, state, halt); end
    endtask

    task automatic test_timeout();
        clear_counts(ERR_TIMEOUT);
        for (int i = 0; i < 16; i++) push(S_IF, 1'b0, 1'b0, OP_RTYPE);
        push(S_HALT, 1'b1, 1'b0, OP_RTYPE);
        while (exp_q.size() != 0) begin
            mem_ready = rdy_q.pop_front(); zero = zero_q.pop_front(); opcode = op_q.pop_front(); #1;
            exp_s = exp_q.pop_front(); exp_m = model(exp_s, mem_ready, zero);
            checks++; if (state !== exp_s) begin errors++; $display("FAIL if_timeout_state: got %0d want %0d", state, exp_s); end
            checks++; if (((ctl ^ exp_m[33:17]) & exp_m[16:0]) !== 17'd0) begin errors++; $display("FAIL if_timeout_ctl: got %b want %b mask %b", ctl, exp_m[33:17], exp_m[16:0]); end
            checks++; if (err_code !== ((exp_s == 4'(S_HALT)) ? task_err : 2'b00)) begin errors++; $display("FAIL if_timeout_err: got %b in state %0d", err_code, exp_s); end
            tick();
        end
        do_reset();
        // same limit applies to a load stuck in MRD
        push(S_IF, 1'b1, 1'b0, OP_LW);
        push(S_ID, 1'b0, 1'b0, OP_LW);
        push(S_MA, 1'b1, 1'b0, OP_LW);
        for (int i = 0; i < 16; i++) push(S_MRD, 1'b0, 1'b0, OP_LW);
        push(S_HALT, 1'b0, 1'b0, OP_LW);
        while (exp_q.size() != 0) begin
            mem_ready = rdy_q.pop_front(); zero = zero_q.pop_front(); opcode = op_q.pop_front(); #1;
            exp_s = exp_q.pop_front(); exp_m = model(exp_s, mem_ready, zero);
            checks++; if (state !== exp_s) begin errors++; $display("FAIL mrd_timeout_state: got %0d want %0d", state, exp_s); end
            checks++; if (((ctl ^ exp_m[33:17]) & exp_m[16:0]) !== 17'd0) begin errors++; $display("FAIL mrd_timeout_ctl: got %b want %b mask %b", ctl, exp_m[33:17], exp_m[16:0]); end
            checks++; if (err_code !== ((exp_s == 4'(S_HALT)) ? task_err : 2'b00)) begin errors++; $display("FAIL mrd_timeout_err: got %b in state %0d", err_code, exp_s); end
            tick();
        end
        do_reset();
    endtask

    task automatic test_timeout_edge();
        clear_counts(2'b00);
        push_instr(OP_RTYPE, 1'b0, 15, 0);
        while (exp_q.size() != 0) begin
            mem_ready = rdy_q.pop_front(); zero = zero_q.pop_front(); opcode = op_q.pop_front(); #1;
            exp_s = exp_q.pop_front(); exp_m = model(exp_s, mem_ready, zero);
            checks++; if (state !== exp_s) begin errors++; $display("FAIL if_edge_state: got %0d want %0d", state, exp_s); end
            checks++; if (((ctl ^ exp_m[33:17]) & exp_m[16:0]) !== 17'd0) begin errors++; $display("FAIL if_edge_ctl: got %b want %b mask %b", ctl, exp_m[33:17], exp_m[16:0]); end
            checks++; if (err_code !== 2'b00) begin errors++; $display("FAIL if_edge_err: got %b want 00", err_code); end
            tick();
        end
    endtask

    task automatic test_async_reset();
        push(S_IF, 1'b1, 1'b0, OP_SW);
        push(S_ID, 1'b1, 1'b0, OP_SW);
        push(S_MA, 1'b1, 1'b0, OP_SW);
        while (exp_q.size() != 0) begin
            mem_ready = rdy_q.pop_front(); zero = zero_q.pop_front(); opcode = op_q.pop_front(); #1;
            exp_s = exp_q.pop_front();
            checks++; if (state !== exp_s) begin errors++; $display("FAIL arst_state: got %0d want %0d", state, exp_s); end
            tick();
        end
        mem_ready = 1'b0;
        #1;
        checks++;
        if (state !== 4'(S_MWR) || mem_req !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL arst_in_mwr: state=%0d req=%b we=%b want 5/1/1", state, mem_req, mem_we); end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || state !== 4'(S_IF)) begin errors++; $display("FAIL arst_drop: req=%b we=%b state=%0d want 0/0/0", mem_req, mem_we, state); end
        mem_ready = 1'b1;
        tick();
        checks++;
        if (ctl !== 17'd0) begin errors++; $display("FAIL arst_held: got %b want all zero", ctl); end
        rst = 1'b1;
        mem_ready = 1'b0;
        #1;
        checks++;
        if (state !== 4'(S_IF) || mem_req !== 1'b1 || iord !== 1'b0) begin errors++; $display("FAIL arst_release: state=%0d req=%b iord=%b want 0/1/0", state, mem_req, iord); end
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops [6];
        int n_instr;
        ops[0] = OP_RTYPE; ops[1] = OP_LW; ops[2] = OP_SW;
        ops[3] = OP_BEQ; ops[4] = OP_J; ops[5] = OP_ADDI;
        clear_counts(2'b00);
        n_instr = 24;
        for (int k = 0; k < n_instr; k++)
            push_instr(ops[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
        while (exp_q.size() != 0) begin
            mem_ready = rdy_q.pop_front(); zero = zero_q.pop_front(); opcode = op_q.pop_front(); #1;
            exp_s = exp_q.pop_front(); exp_m = model(exp_s, mem_ready, zero);
            checks++; if (state !== exp_s) begin errors++; $display("FAIL b2b_state: got %0d want %0d", state, exp_s); end
            checks++; if (((ctl ^ exp_m[33:17]) & exp_m[16:0]) !== 17'd0) begin errors++; $display("FAIL b2b_ctl: state %0d got %b want %b mask %b", exp_s, ctl, exp_m[33:17], exp_m[16:0]); end
            if (retire === 1'b1) n_ret++;
            tick();
        end
        checks++;
        if (n_ret != n_instr) begin errors++; $display("FAIL b2b_retire: got %0d want %0d", n_ret, n_instr); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b0; mem_ready = 1'b0; zero = 1'b0; opcode = 6'd0;
        test_reset();
        test_rtype();
        test_lw();
        test_beq();
        test_illegal();
        test_timeout();
        test_timeout_edge();
        test_async_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
